hdmi_video_timing_gen: RTL and testbench
========================================

Name: hdmi_video_timing_gen

Overview:
Pixel-clock-domain source that feeds the HDMI transceiver's red/green/blue inputs.
- Generates raster timing (hsync, vsync, data enable) and a selectable test pattern.
- Replaces the constant-colour tie-off in HDMI bring-up tops.
- Runs on the PLL pixel clock (clk_low) that also drives the transceiver's low-speed domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync

Ports:
clk_low  input  1  pixel clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = run raster; 0 = hold idle at (0,0)
pattern_sel  input  2  test pattern select, sampled at frame start
hsync  output  1  horizontal sync, registered
vsync  output  1  vertical sync, registered
de  output  1  data enable: 1 in active area
red  output  8  pixel red
green  output  8  pixel green
blue  output  8  pixel blue
x  output  11  active-area column of current output pixel (0 when de=0)
y  output  11  active-area line of current output pixel (0 when de=0)
frame_start  output  1  one-cycle pulse with pixel (0,0)

Behaviour:
- Clock/reset: one clock (clk_low). Reset is asynchronous and active-high, port name reset.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it counts 0..V_TOTAL-1 and wraps to 0 on the same cycle h_cnt wraps.
  - Widths are 11 bits; parameter totals up to 2047 are supported.
- Regions, decoded from counters:
  - active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hsync asserted: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted: V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines. vsync changes on the same cycle as the h_cnt=0 decode.
- Latency: every output is registered and reflects counter state one cycle earlier. hsync, vsync, de, rgb, x, y and frame_start stay mutually aligned.
- Reset values: hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, red=green=blue=0, x=y=0, frame_start=0, h_cnt=v_cnt=0, active pattern=0.
- Reset mid-frame: immediate return to reset values. After deassertion, the first enabled cycle outputs pixel (0,0) with frame_start=1.
- enable=0:
  - Counters are forced to 0 and all outputs take their reset values on the next edge.
  - When enable rises, the first output (one edge later) is pixel (0,0) with frame_start=1.
- frame_start is 1 exactly when the output pixel is (0,0) with de=1; it is 0 on all other cycles.
- pattern_sel:
  - Captured into the active pattern register only when h_cnt=0 and v_cnt=0 (frame start). Changes mid-frame take effect at the next frame.
  - 0: 8 vertical colour bars, width BAR_W=H_ACTIVE/8, in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. The bar index comes from a running counter, with no divider. Any remainder pixels of H_ACTIVE belong to bar 7.
  - 1: grey ramp; red=green=blue=x[7:0] (wraps every 256 pixels).
  - 2: 32-pixel checkerboard; x[5]^y[5]=0 gives FFFFFF, 1 gives 000000.
  - 3: solid green 00FF00.
- Outside the active area: red=green=blue=0 and x=y=0, regardless of pattern.

Test Plan:
- Reset then enable=1, default params: hsync low for exactly 96 cycles per 800-cycle line, starting 656 cycles after de rises. de high 640 cycles per line for 480 lines. vsync low for 2 full lines starting at line 490. Period is 420000 cycles.
- pattern_sel=0: pixel x=0 gives FFFFFF, x=79 FFFFFF, x=80 FFFF00, x=559 0000FF, x=560 000000, x=639 000000. rgb is 0 while de=0.
- pattern_sel=1 and 2: x=300 gives 2C2C2C. Checkerboard at (31,0)=FFFFFF, (32,0)=000000, (32,32)=FFFFFF.
- Change pattern_sel 0→3 at line 100: the rest of the frame stays bars. The next frame is all 00FF00. frame_start pulses once per 420000 cycles, aligned with de rise.
- Assert reset for 3 cycles at line 200, pixel 123: outputs go to reset values asynchronously. The first output after release is (0,0) with frame_start=1 and hsync/vsync at inactive levels.
- enable=0 for 1000 cycles mid-line: de=0, rgb=0, syncs inactive. Re-enable: next output is (0,0) with frame_start=1. Small-params build (H 8/1/2/1, V 4/1/1/1) matches the same checks with exact cycle counts.

Source files
------------

// File: rtl/hdmi_video_timing_gen.sv
// Raster timing and test-pattern source for the HDMI transceiver rgb inputs.
// All outputs registered; they reflect the counter state of the previous cycle.
module hdmi_video_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        clk_low,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        frame_start
);

  localparam logic [10:0] HA    = 11'(H_ACTIVE);
  localparam logic [10:0] HS0   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_END = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] VA    = 11'(V_ACTIVE);
  localparam logic [10:0] VS0   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_END = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] BAR_L = 11'(H_ACTIVE / 8 - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [10:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [1:0]  pat_q, pat_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [23:0] rgb_q, rgb_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        fs_q, fs_d;

  logic        h_wrap, v_wrap, sof, active;
  logic [1:0]  pat;
  logic [23:0] bar_rgb, colour;

  always_comb begin
    h_wrap = (h_cnt_q == H_END);
    v_wrap = (v_cnt_q == V_END);
    sof    = (h_cnt_q == '0) && (v_cnt_q == '0);
    active = (h_cnt_q < HA) && (v_cnt_q < VA);
    // The pattern for pixel (0,0) already uses the newly sampled select.
    pat    = sof ? pattern_sel : pat_q;

    case (bar_idx_q)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase

    case (pat)
      2'd0:    colour = bar_rgb;
      2'd1:    colour = {3{h_cnt_q[7:0]}};
      2'd2:    colour = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'h000000 : 24'hFFFFFF;
      default: colour = 24'h00FF00;
    endcase

    h_cnt_d   = '0;
    v_cnt_d   = '0;
    bar_cnt_d = '0;
    bar_idx_d = '0;
    pat_d     = pat_q;
    hsync_d   = ~HSYNC_POL;
    vsync_d   = ~VSYNC_POL;
    de_d      = 1'b0;
    rgb_d     = '0;
    x_d       = '0;
    y_d       = '0;
    fs_d      = 1'b0;

    if (enable) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 11'd1;
      v_cnt_d = v_cnt_q;
      if (h_wrap)
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 11'd1;

      // Bar position tracks h_cnt; leftover pixels stay in the last bar.
      bar_cnt_d = bar_cnt_q;
      bar_idx_d = bar_idx_q;
      if (h_wrap) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if (h_cnt_q < HA) begin
        if (bar_cnt_q == BAR_L && bar_idx_q != 3'd7) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 11'd1;
        end
      end

      pat_d = pat;
      if (h_cnt_q >= HS0 && h_cnt_q < HS1)
        hsync_d = HSYNC_POL;
      if (v_cnt_q >= VS0 && v_cnt_q < VS1)
        vsync_d = VSYNC_POL;
      de_d  = active;
      rgb_d = active ? colour : '0;
      x_d   = active ? h_cnt_q : '0;
      y_d   = active ? v_cnt_q : '0;
      fs_d  = sof && active;
    end
  end

  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      pat_q     <= '0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      de_q      <= 1'b0;
      rgb_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      rgb_q     <= rgb_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Scoreboard bench: 640-pixel lines with a short 38-line frame.
// Stimulus queues expected pixels, snapshots and timing intervals.
module tb_hdmi_video_timing_gen;

  logic        clk_low;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        hsync, vsync, de, frame_start;
  logic [7:0]  red, green, blue;
  logic [10:0] x, y;

  hdmi_video_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(34), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk_low(clk_low), .reset(reset), .enable(enable),
    .pattern_sel(pattern_sel), .hsync(hsync), .vsync(vsync),
    .de(de), .red(red), .green(green), .blue(blue),
    .x(x), .y(y), .frame_start(frame_start)
  );

  initial clk_low = 1'b0;
  always #5 clk_low = ~clk_low;

  typedef struct {
    int          px;
    int          py;
    logic [23:0] rgb;
    logic        fs;
  } pix_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
  } snap_t;

  localparam int NK = 8;
  localparam int K_DEW = 0, K_HSW = 1, K_HOFF = 2, K_HPER = 3;
  localparam int K_VSW = 4, K_VLINE = 5, K_DEL = 6, K_PER = 7;
  string kname [NK] = '{"de_width", "hsync_width", "hsync_offset",
                        "line_period", "vsync_width", "vsync_line",
                        "de_lines", "frame_period"};

  int    exp_q [NK][$];
  pix_t  pix_q [$];
  snap_t snap_q [$];
  int    checks = 0;
  int    errors = 0;

  localparam snap_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0,
                             rgb: 24'h0, x: 11'd0, y: 11'd0, fs: 1'b0};

  task automatic obs(input int k, input int v);
    int e;
    if (exp_q[k].size() > 0) begin
      e = exp_q[k].pop_front();
      checks++;
      if (v != e) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", kname[k], v, e);
      end
    end
  endtask

  int   cyc = 0;
  int   fs_cyc, de_rise, hs_fall, vs_fall;
  bit   fs_v = 0, de_rise_v = 0, hs_fall_v = 0;
  int   hs_n = 0, de_n = 0;
  logic de_p = 1'b0, hs_p = 1'b1, vs_p = 1'b1;

  always @(negedge clk_low) begin
    snap_t s, a;
    pix_t  p;
    cyc++;
    a = '{hs: hsync, vs: vsync, de: de, rgb: {red, green, blue},
          x: x, y: y, fs: frame_start};
    if (!de) begin
      checks++;
      if (a.rgb != 0 || x != 0 || y != 0 || frame_start) begin
        errors++;
        $display("FAIL blank: got rgb=%h x=%0d y=%0d fs=%b expected all 0",
                 a.rgb, x, y, frame_start);
      end
    end
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      checks++;
      if (a != s) begin
        errors++;
        $display("FAIL snapshot: got %h expected %h", a, s);
      end
    end
    if (de && pix_q.size() > 0 && int'(x) == pix_q[0].px &&
        int'(y) == pix_q[0].py) begin
      p = pix_q.pop_front();
      checks++;
      if (a.rgb != p.rgb || frame_start != p.fs) begin
        errors++;
        $display("FAIL pixel(%0d,%0d): got rgb=%h fs=%b expected rgb=%h fs=%b",
                 p.px, p.py, a.rgb, frame_start, p.rgb, p.fs);
      end
    end
    if (frame_start) begin
      if (fs_v) obs(K_PER, cyc - fs_cyc);
      fs_v = 1; fs_cyc = cyc; hs_n = 0; de_n = 0;
    end
    if (de && !de_p) begin
      de_rise = cyc; de_rise_v = 1; de_n++;
    end
    if (!de && de_p) obs(K_DEW, cyc - de_rise);
    if (!hsync && hs_p) begin
      if (hs_fall_v) obs(K_HPER, cyc - hs_fall);
      if (de_rise_v) obs(K_HOFF, cyc - de_rise);
      hs_fall = cyc; hs_fall_v = 1; de_rise_v = 0; hs_n++;
    end
    if (hsync && !hs_p) obs(K_HSW, cyc - hs_fall);
    if (!vsync && vs_p) begin
      obs(K_VLINE, hs_n);
      obs(K_DEL, de_n);
      vs_fall = cyc;
    end
    if (vsync && !vs_p) obs(K_VSW, cyc - vs_fall);
    de_p = de; hs_p = hsync; vs_p = vsync;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_low);
    #2;
  endtask

  task automatic px(input int xx, input int yy, input logic [23:0] c,
                    input logic f = 1'b0);
    pix_q.push_back('{px: xx, py: yy, rgb: c, fs: f});
  endtask

  function automatic int pending();
    int n = pix_q.size() + snap_q.size();
    for (int k = 0; k < NK; k++) n += exp_q[k].size();
    return n;
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
    tick(3);
    snap_q.push_back(IDLE);
    reset = 1'b0;
    tick(2);

    // First frame: timing intervals and colour bars.
    for (int i = 0; i < 34; i++) exp_q[K_DEW].push_back(640);
    for (int i = 0; i < 38; i++) exp_q[K_HSW].push_back(96);
    for (int i = 0; i < 34; i++) exp_q[K_HOFF].push_back(656);
    for (int i = 0; i < 37; i++) exp_q[K_HPER].push_back(800);
    exp_q[K_VSW].push_back(1600);
    exp_q[K_VLINE].push_back(35);
    exp_q[K_DEL].push_back(34);
    exp_q[K_PER].push_back(30400);
    px(0, 0, 24'hFFFFFF, 1'b1);
    px(79, 0, 24'hFFFFFF);
    px(80, 0, 24'hFFFF00);
    px(160, 0, 24'h00FFFF);
    px(240, 0, 24'h00FF00);
    px(320, 0, 24'hFF00FF);
    px(400, 0, 24'hFF0000);
    px(559, 0, 24'h0000FF);
    px(560, 0, 24'h000000);
    px(639, 0, 24'h000000);
    px(80, 20, 24'hFFFF00);
    px(639, 33, 24'h000000);
    px(0, 0, 24'h00FF00, 1'b1);
    px(320, 0, 24'h00FF00);
    px(639, 1, 24'h00FF00);
    enable = 1'b1;

    // Mid-frame select change applies only from the next frame.
    tick(1 + 10 * 800 + 5);
    pattern_sel = 2'd3;

    // Asynchronous reset while pixel (123,2) of the second frame shows.
    tick(30400 + 2 * 800 + 123 - 8005);
    reset = 1'b1;
    pattern_sel = 2'd1;
    snap_q.push_back(IDLE);
    tick(1);
    snap_q.push_back(IDLE);
    tick(2);
    px(255, 0, 24'hFFFFFF);
    px(300, 0, 24'h2C2C2C);
    reset = 1'b0;
    tick(1);
    snap_q.push_back('{hs: 1'b1, vs: 1'b1, de: 1'b1, rgb: 24'h0,
                       x: 11'd0, y: 11'd0, fs: 1'b1});

    // Disable for 1000 cycles in the middle of line 1.
    tick(1200);
    enable = 1'b0;
    pattern_sel = 2'd2;
    tick(1);
    snap_q.push_back(IDLE);
    tick(998);
    snap_q.push_back(IDLE);
    tick(1);
    px(31, 0, 24'hFFFFFF);
    px(32, 0, 24'h000000);
    px(0, 32, 24'h000000);
    px(32, 32, 24'hFFFFFF);
    enable = 1'b1;
    tick(1);
    snap_q.push_back('{hs: 1'b1, vs: 1'b1, de: 1'b1, rgb: 24'hFFFFFF,
                       x: 11'd0, y: 11'd0, fs: 1'b1});
    tick(32 * 800 + 100);

    for (int i = 0; i < 2000 && pending() > 0; i++) tick(1);
    if (pix_q.size() > 0) begin
      errors += pix_q.size();
      $display("FAIL pixels_unseen: got %0d left expected 0", pix_q.size());
    end
    if (snap_q.size() > 0) begin
      errors += snap_q.size();
      $display("FAIL snapshots_left: got %0d left expected 0", snap_q.size());
    end
    for (int k = 0; k < NK; k++) begin
      if (exp_q[k].size() > 0) begin
        errors += exp_q[k].size();
        $display("FAIL %s_unseen: got %0d left expected 0",
                 kname[k], exp_q[k].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
